// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receiver: held byte, status flags and the read acknowledge.
interface spart_rx_if;
  logic       clr_rda;
  logic [7:0] rec_buff;
  logic       RDA;
  logic       framing_err;
  logic       overrun;
  logic       rx_busy;

  // The receiver presents data and status; the bus interface acknowledges reads.
  modport slave (
    input  clr_rda,
    output rec_buff, RDA, framing_err, overrun, rx_busy
  );

  modport master (
    output clr_rda,
    input  rec_buff, RDA, framing_err, overrun, rx_busy
  );
endinterface

// File: rtl/spart_rx.sv
// SPART serial receiver: oversamples rxd on the baud tick and deframes 8N1 characters, LSB first.
// The last good byte is held with RDA, framing and overrun status until the bus reads it.
module spart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rxd,
  spart_rx_if.slave   bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, next_state;
  logic          rxd_meta, rxd_s;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  logic          cnt_clr, bit_clr, shift_en, stop_sample;

  // NOTE: every clocked process uses non-blocking assignments so all flops see
  // pre-edge values; blocking here would make rxd_s follow rxd in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: all outputs of this block get a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    cnt_clr     = 1'b0;
    bit_clr     = 1'b0;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !rxd_s) begin
          next_state = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (enable && sample_cnt == HALF_CNT) begin
          // A start bit that is gone by mid-bit was a glitch, not a character.
          if (!rxd_s) begin
            next_state = DATA;
            cnt_clr    = 1'b1;
            bit_clr    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (enable && sample_cnt == LAST_CNT) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) next_state = STOP;
        end
      end
      STOP: begin
        if (enable && sample_cnt == LAST_CNT) begin
          stop_sample = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      if (cnt_clr)
        sample_cnt <= '0;
      else if (enable && state != IDLE)
        sample_cnt <= sample_cnt + 1'b1;

      if (bit_clr)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;

      if (shift_en)
        shift_reg <= {rxd_s, shift_reg[7:1]};
    end
  end

  // Status: a good frame outranks a same-cycle read, and that read still
  // consumes the old byte, so no overrun is flagged in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rec_buff    <= 8'h00;
      bus.RDA         <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun     <= 1'b0;
    end else if (stop_sample && rxd_s) begin
      bus.rec_buff    <= shift_reg;
      bus.RDA         <= 1'b1;
      bus.framing_err <= 1'b0;
      if (bus.RDA && !bus.clr_rda) bus.overrun <= 1'b1;
      else if (bus.clr_rda)        bus.overrun <= 1'b0;
    end else begin
      if (stop_sample) bus.framing_err <= 1'b1;
      if (bus.clr_rda) begin
        bus.RDA     <= 1'b0;
        bus.overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_busy = (state != IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: each frame pushes its expected status, and a monitor
// compares the bus outputs whenever rx_busy falls.
module tb_spart_rx;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic rxd;

  spart_rx_if bus_if ();

  spart_rx #(.OVERSAMPLE(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rxd    (rxd),
    .bus    (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       rda;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] data, input logic rda, input logic fe, input logic ov);
    exp_t e;
    e.data = data; e.rda = rda; e.fe = fe; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  // One 8N1 frame, 16 clocks per bit; clr_at / rst_at pulse those inputs at a frame-relative cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int clr_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      rxd            = bits[i / 16];
      bus_if.clr_rda = (i == clr_at);
      rst            = (i == rst_at);
    end
    @(negedge clk);
    bus_if.clr_rda = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus_if.clr_rda = 1'b1;
    @(negedge clk);
    bus_if.clr_rda = 1'b0;
    check("clr_rda_RDA", 32'(bus_if.RDA), 32'd0);
    check("clr_rda_overrun", 32'(bus_if.overrun), 32'd0);
  endtask

  // Monitor: every end of activity must match the oldest expectation.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !bus_if.rx_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_end", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rec_buff", 32'(bus_if.rec_buff), 32'(e.data));
          check("RDA", 32'(bus_if.RDA), 32'(e.rda));
          check("framing_err", 32'(bus_if.framing_err), 32'(e.fe));
          check("overrun", 32'(bus_if.overrun), 32'(e.ov));
        end
      end
      prev_busy = bus_if.rx_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    rxd            = 1'b1;
    bus_if.clr_rda = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rec_buff", 32'(bus_if.rec_buff), 32'h00);
    check("reset_RDA", 32'(bus_if.RDA), 32'd0);
    check("reset_framing_err", 32'(bus_if.framing_err), 32'd0);
    check("reset_overrun", 32'(bus_if.overrun), 32'd0);
    check("reset_rx_busy", 32'(bus_if.rx_busy), 32'd0);
    idle(5);

    // False start: 4 ticks low, rejected at the mid-start-bit check.
    push(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    idle(30);

    push(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(5);
    pulse_clr();

    // Framing error keeps the old byte; the low stop bit then reads as a false start.
    push(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, -1);
    pulse_clr();
    push(8'h3C, 1'b0, 1'b1, 1'b0);
    push(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, -1, -1);
    idle(30);
    push(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, -1, -1);
    pulse_clr();

    // Overrun: back-to-back without a read.
    push(8'h12, 1'b1, 1'b0, 1'b0);
    push(8'h34, 1'b1, 1'b0, 1'b1);
    send_frame(8'h12, 1'b1, -1, -1);
    send_frame(8'h34, 1'b1, -1, -1);
    pulse_clr();

    // Collision: clr_rda lands on the completion edge (frame cycle 154) of 0x77.
    push(8'h66, 1'b1, 1'b0, 1'b0);
    push(8'h77, 1'b1, 1'b0, 1'b0);
    send_frame(8'h66, 1'b1, -1, -1);
    send_frame(8'h77, 1'b1, 154, -1);
    idle(5);
    check("collision_rec_buff", 32'(bus_if.rec_buff), 32'h77);
    check("collision_RDA", 32'(bus_if.RDA), 32'd1);
    check("collision_overrun", 32'(bus_if.overrun), 32'd0);
    pulse_clr();

    // Reset after data bit 3 of 0xF0; the rest of that frame must be ignored.
    push(8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, -1, 80);
    idle(10);
    check("midreset_rec_buff", 32'(bus_if.rec_buff), 32'h00);
    check("midreset_RDA", 32'(bus_if.RDA), 32'd0);
    check("midreset_rx_busy", 32'(bus_if.rx_busy), 32'd0);
    push(8'hC3, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(30);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive stage of the SPART. It oversamples `rxd` using the 16x baud tick from the baud generator and deframes 8N1 characters, LSB first. It holds the last good byte in `rec_buff` with the `RDA` flag for the bus interface, which reads it over `DATABUS` and acknowledges with `clr_rda`. Framing and overrun status are reported alongside the data.

## Interface
- `OVERSAMPLE`, default 16: enable ticks per bit period; power of two, at least 4.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  baud tick at OVERSAMPLE x bit rate; single-cycle pulse.
- `rxd`  in  1  asynchronous serial input; idle high.
- `clr_rda`  in  1  single-cycle pulse from the bus interface on a receive-buffer read (IOCS & IORW & IOADDR==00).
- `rec_buff`  out  8  last correctly framed byte.
- `RDA`  out  1  receive data available.
- `framing_err`  out  1  the most recent frame had stop bit = 0.
- `overrun`  out  1  a byte was overwritten while RDA was still 1.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer:
  - `rxd` passes through 2 flops, each resetting to 1.
  - All sampling uses the second flop, `rxd_s`.
- Counters:
  - Sample counter: log2(OVERSAMPLE) bits; increments only on `enable`.
  - Bit counter: 3 bits, values 0..7.
- State machine, IDLE / START / DATA / STOP:
  - IDLE: on `enable` with `rxd_s`==0, go to START and clear the sample counter.
  - START: at sample count OVERSAMPLE/2-1 (mid start bit), re-check `rxd_s`.
    - If it is 0, go to DATA and clear both counters.
    - If it is 1, this is a false start: return to IDLE. No flags change.
  - DATA: when the sample counter wraps to OVERSAMPLE-1 (mid-bit), shift `rxd_s` into bit 7 of the shift register (right shift, LSB first).
    - After the 8th sample (bit counter = 7), go to STOP.
  - STOP: at mid stop bit, sample `rxd_s`, then return to IDLE.
    - Sample = 1: `rec_buff` <= shift register, `RDA` <= 1, `framing_err` <= 0.
      - If `RDA` was already 1 at this point, also set `overrun` <= 1.
    - Sample = 0: `framing_err` <= 1. `rec_buff`, `RDA` and `overrun` are unchanged.
- `clr_rda`: clears `RDA` and `overrun`. `framing_err` is cleared only by the next good frame or by reset.
- Simultaneous `clr_rda` and good-frame completion in the same cycle:
  - Set wins: `RDA` = 1 with the new data.
  - `overrun` = 0, because the old byte was consumed.
- `enable` low: all counters hold and the state holds. `rxd` edges are ignored except through the synchronizer.
- Reset mid-frame:
  - Next cycle: state IDLE, counters 0, shift register 0.
  - The partial frame is discarded.
  - Reception restarts only on a new falling edge seen in IDLE.

## Timing
- Reset values:
  - `rec_buff` = 8'h00
  - `RDA`, `framing_err`, `overrun`, `rx_busy` = 0
  - both synchronizer flops = 1
- `rxd` to `rxd_s` latency: 2 clk.
- Bit period: OVERSAMPLE enable ticks.
- Sample points:
  - Start bit: tick OVERSAMPLE/2 after detection.
  - Data bit n (n = 0..7): a further (n+1)·OVERSAMPLE ticks after the start-bit sample.
  - Stop bit: a further OVERSAMPLE ticks after data bit 7.
- `RDA` / `rec_buff` / `framing_err` / `overrun` update: registered, visible the clk after the stop-sample `enable` cycle.
- `rx_busy`:
  - Rises the clk after the IDLE detection tick.
  - Falls the clk after the stop sample.
  - A new start bit can therefore be detected from the next `enable` onward, which allows back-to-back frames.
- `clr_rda` takes effect on the next clk edge.

## Test plan
- Good frame, OVERSAMPLE=16, `enable` high every cycle, send 0xA5 (8N1) -> after the stop sample `rec_buff`=8'hA5, `RDA`=1, `framing_err`=0, `overrun`=0, `rx_busy`=0.
- False start: drive `rxd` low for 4 ticks, then high -> state returns to IDLE, `RDA`=0, `rec_buff`=8'h00, `rx_busy` pulses then returns to 0.
- Framing error: receive 0x3C, then 0x5A with stop bit forced 0 -> `rec_buff` stays 8'h3C, `framing_err`=1. A following good 0x11 gives `rec_buff`=8'h11 and `framing_err`=0.
- Overrun: 0x12 then 0x34 back-to-back with no `clr_rda` -> `rec_buff`=8'h34, `RDA`=1, `overrun`=1. One `clr_rda` pulse then gives `RDA`=0 and `overrun`=0.
- Collision: pulse `clr_rda` in the exact completion cycle of byte 0x77 while `RDA`=1 -> `RDA`=1, `rec_buff`=8'h77, `overrun`=0.
- Reset mid-frame: assert `rst` for 1 cycle after data bit 3 of 0xF0 -> all outputs at reset values, and the remaining bits of 0xF0 are not captured. The next frame, 0xC3, is received correctly with `RDA`=1.
